// File: rtl/shake_pkg.sv
// Shared constants, types and FSM encoding for the SHAKE256 absorb front end.
package shake_pkg;

   localparam int RATE_LANES = 17;
   localparam int RATE_BYTES = 136;
   localparam logic [7:0] DSBYTE_SHAKE256 = 8'h1F;
   localparam logic [7:0] PAD_END_BYTE = 8'h80;

   // MSB of the last rate byte (byte 135) within the 1600-bit state.
   localparam int PAD_END_MSB = 1599 - 8 * (RATE_BYTES - 1);

   typedef logic [1599:0] state_t;
   typedef logic [63:0]   lane_t;

   typedef enum logic [2:0] {
      ST_ABSORB,
      ST_LOAD,
      ST_RUN,
      ST_PADBLK,
      ST_OUTPUT
   } fsm_t;

   // MSB position of lane idx; lane 0 holds state bytes 0..7 at the top of the vector.
   function automatic int lane_msb(input logic [4:0] idx);
      return 1599 - 64 * int'(idx);
   endfunction

endpackage

// File: rtl/shake_pad_lane.sv
// Combinational lane conditioner: masks the unused tail of a final word and
// places the domain-separation byte. Also reports where the remaining pad
// bytes must go (byte 0 of the next lane, byte 135 of the block).
module shake_pad_lane
   import shake_pkg::*;
(
   input  lane_t      lane_i,
   input  logic [3:0] nbytes_i,
   input  logic [4:0] idx_i,
   input  logic       last_i,
   output lane_t      lane_o,
   output logic       ds_next_o,
   output logic       pad_end_o
);

   logic full_tail;

   // A final word that exactly fills the block leaves no room for padding here;
   // the pad then goes into an extra block.
   assign full_tail = (idx_i == 5'(RATE_LANES - 1)) && (nbytes_i >= 4'd8);

   // A full final word earlier in the block pushes the DS byte into the next lane.
   assign ds_next_o = last_i && (nbytes_i >= 4'd8) && !full_tail;
   assign pad_end_o = last_i && !full_tail;

   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_byte
         logic keep;
         logic ds;
         assign keep = !last_i || (nbytes_i > 4'(gi));
         assign ds   = last_i && (nbytes_i == 4'(gi));
         assign lane_o[63-8*gi -: 8] = (keep ? lane_i[63-8*gi -: 8] : 8'h00)
                                     ^ (ds ? DSBYTE_SHAKE256 : 8'h00);
      end
   endgenerate

endmodule

// File: rtl/shake256_absorb.sv
// SHAKE256 sponge absorb and pad stage: XORs 64-bit message words into the
// rate part of the state, applies 0x1F..0x80 padding, sequences KECCAK_f and
// hands the absorbed state to the squeeze stage.
module shake256_absorb
   import shake_pkg::*;
(
   input  logic         clock_i,
   input  logic         reset_i,
   input  logic         in_valid_i,
   output logic         in_ready_o,
   input  logic [63:0]  in_data_i,
   input  logic         in_last_i,
   input  logic [3:0]   in_bytes_i,
   output logic [1599:0] perm_state_out_o,
   output logic         perm_run_o,
   input  logic         perm_done_i,
   input  logic [1599:0] perm_state_in_i,
   output logic         out_valid_o,
   input  logic         out_ready_i,
   output logic [1599:0] out_state_o
);

   fsm_t       state_q, state_d;
   state_t     s_q, s_d;
   logic [4:0] lane_q, lane_d;
   logic       fin_q, fin_d;
   logic       pad_q, pad_d;

   // Operands of the shared pad/XOR path: the incoming word in ABSORB, or an
   // empty final word at lane 0 in PADBLK (yields 0x1F at byte 0 plus 0x80 at 135).
   lane_t      op_data;
   logic [3:0] op_nbytes;
   logic [4:0] op_idx;
   logic       op_last;
   lane_t      pad_lane;
   logic       ds_next;
   logic       pad_end;
   state_t     s_upd;
   logic       accept;

   // Select pad-path operands depending on whether a word or the pad block is applied.
   always_comb begin
      op_data   = in_data_i;
      op_nbytes = in_bytes_i;
      op_idx    = lane_q;
      op_last   = in_last_i;
      if (state_q == ST_PADBLK) begin
         op_data   = '0;
         op_nbytes = 4'd0;
         op_idx    = 5'd0;
         op_last   = 1'b1;
      end
   end

   shake_pad_lane u_pad_lane (
      .lane_i    (op_data),
      .nbytes_i  (op_nbytes),
      .idx_i     (op_idx),
      .last_i    (op_last),
      .lane_o    (pad_lane),
      .ds_next_o (ds_next),
      .pad_end_o (pad_end)
   );

   // State after XORing the conditioned lane and any spill-over pad bytes.
   always_comb begin
      s_upd = s_q;
      s_upd[lane_msb(op_idx) -: 64] = s_q[lane_msb(op_idx) -: 64] ^ pad_lane;
      if (ds_next) begin
         s_upd[lane_msb(5'(op_idx + 5'd1)) -: 8] =
            s_upd[lane_msb(5'(op_idx + 5'd1)) -: 8] ^ DSBYTE_SHAKE256;
      end
      if (pad_end) begin
         s_upd[PAD_END_MSB -: 8] = s_upd[PAD_END_MSB -: 8] ^ PAD_END_BYTE;
      end
   end

   // Next-state and output decode for the absorb sequencer.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      lane_d      = lane_q;
      fin_d       = fin_q;
      pad_d       = pad_q;
      in_ready_o  = (state_q == ST_ABSORB) && !reset_i;
      perm_run_o  = (state_q == ST_RUN);
      out_valid_o = (state_q == ST_OUTPUT);
      accept      = in_valid_i && in_ready_o;

      case (state_q)
         ST_ABSORB: begin
            if (accept) begin
               s_d = s_upd;
               if (!in_last_i) begin
                  if (lane_q == 5'(RATE_LANES - 1)) begin
                     state_d = ST_LOAD;
                     fin_d   = 1'b0;
                  end else begin
                     lane_d = 5'(lane_q + 5'd1);
                  end
               end else begin
                  state_d = ST_LOAD;
                  if (pad_end) begin
                     fin_d = 1'b1;
                  end else begin
                     // Message ended exactly on a block boundary: pad goes in a block of its own.
                     fin_d = 1'b0;
                     pad_d = 1'b1;
                  end
               end
            end
         end
         ST_LOAD: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (perm_done_i) begin
               s_d    = perm_state_in_i;
               lane_d = 5'd0;
               if (pad_q) begin
                  state_d = ST_PADBLK;
               end else if (fin_q) begin
                  state_d = ST_OUTPUT;
               end else begin
                  state_d = ST_ABSORB;
               end
            end
         end
         ST_PADBLK: begin
            s_d     = s_upd;
            pad_d   = 1'b0;
            fin_d   = 1'b1;
            state_d = ST_LOAD;
         end
         ST_OUTPUT: begin
            if (out_ready_i) begin
               s_d     = '0;
               lane_d  = 5'd0;
               fin_d   = 1'b0;
               state_d = ST_ABSORB;
            end
         end
         default: begin
            state_d = ST_ABSORB;
         end
      endcase
   end

   // Registered state with synchronous reset.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= ST_ABSORB;
         s_q     <= '0;
         lane_q  <= 5'd0;
         fin_q   <= 1'b0;
         pad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         lane_q  <= lane_d;
         fin_q   <= fin_d;
         pad_q   <= pad_d;
      end
   end

   assign perm_state_out_o = s_q;
   assign out_state_o      = s_q;

   // A final word may carry at most 8 valid bytes.
   a_in_bytes_legal: assert property (@(posedge clock_i) disable iff (reset_i)
      (in_valid_i && in_ready_o && in_last_i) |-> (in_bytes_i <= 4'd8));

endmodule

// File: tb/tb_shake256_absorb.sv
// Bench for shake256_absorb: a stand-in permutation with random latency and
// a byte-level sponge model (pad to 136-byte blocks, XOR, permute).
module tb_shake256_absorb;
   import shake_pkg::*;

   logic         clock, reset;
   logic         in_valid, in_ready, in_last;
   logic [63:0]  in_data;
   logic [3:0]   in_bytes;
   state_t       perm_state_out, perm_state_in, out_state;
   logic         perm_run, perm_done, out_valid, out_ready;

   int           n_tests, n_fail;
   logic [7:0]   msg[$];
   state_t       exp_loads[$];
   state_t       load_q[$];
   state_t       exp_out;
   state_t       empty_ref;
   int           run_cnt, run_lat;
   state_t       run_cap;

   shake256_absorb dut (
      .clock_i          (clock),
      .reset_i          (reset),
      .in_valid_i       (in_valid),
      .in_ready_o       (in_ready),
      .in_data_i        (in_data),
      .in_last_i        (in_last),
      .in_bytes_i       (in_bytes),
      .perm_state_out_o (perm_state_out),
      .perm_run_o       (perm_run),
      .perm_done_i      (perm_done),
      .perm_state_in_i  (perm_state_in),
      .out_valid_o      (out_valid),
      .out_ready_i      (out_ready),
      .out_state_o      (out_state)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Stand-in permutation: any fixed bijection-like mix is enough to track blocks.
   function automatic state_t perm_f(input state_t s);
      return {s[1586:0], s[1599:1587]} ^ {25{64'h9E3779B97F4A7C15}};
   endfunction

   // Permutation responder: records the state presented on entry to RUN,
   // answers after a random latency, and sometimes pulses perm_done while idle.
   initial begin
      perm_done     = 1'b0;
      perm_state_in = '0;
      run_cnt       = 0;
      run_lat       = 1;
      forever begin
         @(negedge clock);
         perm_done = 1'b0;
         if (perm_run === 1'b1) begin
            run_cnt++;
            if (run_cnt == 1) begin
               run_cap = perm_state_out;
               load_q.push_back(run_cap);
            end
            if (run_cnt == run_lat) begin
               perm_done     = 1'b1;
               perm_state_in = perm_f(run_cap);
            end
         end else begin
            run_cnt = 0;
            run_lat = $urandom_range(1, 4);
            if ($urandom_range(0, 7) == 0) begin
               perm_done     = 1'b1;
               perm_state_in = {25{$urandom, $urandom}};
            end
         end
      end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_state(input string tag, input state_t obs, input state_t exp);
      int li;
      li = 0;
      for (int l = 24; l >= 0; l--) begin
         if (obs[1599-64*l -: 64] !== exp[1599-64*l -: 64]) li = l;
      end
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: lane %0d observed %h expected %h", tag, li,
                obs[1599-64*li -: 64], exp[1599-64*li -: 64]);
      end
   endtask

   // Reference sponge: pad message bytes, absorb block by block.
   task automatic build_expect();
      logic [7:0] pb[$];
      state_t     s;
      pb = msg;
      pb.push_back(8'h1F);
      while (pb.size() % 136 != 0) pb.push_back(8'h00);
      pb[pb.size()-1] = pb[pb.size()-1] ^ 8'h80;
      s = '0;
      exp_loads.delete();
      for (int b = 0; b < pb.size() / 136; b++) begin
         for (int i = 0; i < 136; i++) begin
            s[1599-8*i -: 8] = s[1599-8*i -: 8] ^ pb[136*b+i];
         end
         exp_loads.push_back(s);
         s = perm_f(s);
      end
      exp_out = s;
   endtask

   task automatic fill_msg(input int len);
      msg.delete();
      repeat (len) msg.push_back(8'($urandom));
   endtask

   task automatic send_word(input logic [63:0] d, input logic l, input logic [3:0] nb);
      int cnt;
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
         in_valid = 1'b0;
         in_data  = {$urandom, $urandom};
         in_last  = 1'($urandom);
         in_bytes = 4'($urandom_range(0, 8));
         @(negedge clock);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      in_bytes = nb;
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 3000) begin
         @(negedge clock);
         cnt++;
      end
      chk("in_ready_before_accept", 64'(in_ready), 64'd1);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   task automatic stream_msg();
      int nwords;
      int len;
      len    = msg.size();
      nwords = (len == 0) ? 1 : (len + 7) / 8;
      for (int w = 0; w < nwords; w++) begin
         logic [63:0] d;
         logic        l;
         logic [3:0]  nb;
         d = '0;
         for (int k = 0; k < 8; k++) begin
            d[63-8*k -: 8] = (8*w + k < len) ? msg[8*w+k] : 8'($urandom);
         end
         l  = (w == nwords - 1);
         nb = l ? 4'(len - 8*w) : 4'($urandom);
         send_word(d, l, nb);
      end
   endtask

   task automatic run_msg(input string tag, input int bp);
      int cnt;
      int nl;
      build_expect();
      load_q.delete();
      stream_msg();
      cnt = 0;
      while (out_valid !== 1'b1 && cnt < 3000) begin
         @(negedge clock);
         cnt++;
      end
      chk({tag, " out_valid"}, 64'(out_valid), 64'd1);
      chk_state({tag, " out_state"}, out_state, exp_out);
      chk({tag, " perm_count"}, 64'(load_q.size()), 64'(exp_loads.size()));
      nl = (load_q.size() < exp_loads.size()) ? load_q.size() : exp_loads.size();
      for (int i = 0; i < nl; i++) begin
         chk_state($sformatf("%s load%0d", tag, i), load_q[i], exp_loads[i]);
      end
      for (int c = 0; c < bp; c++) begin
         @(negedge clock);
         chk({tag, " bp out_valid"}, 64'(out_valid), 64'd1);
         chk({tag, " bp in_ready"}, 64'(in_ready), 64'd0);
         chk_state({tag, " bp out_state"}, out_state, exp_out);
      end
      out_ready = 1'b1;
      @(negedge clock);
      out_ready = 1'b0;
      chk({tag, " post in_ready"}, 64'(in_ready), 64'd1);
      chk({tag, " post out_valid"}, 64'(out_valid), 64'd0);
      chk_state({tag, " post S"}, perm_state_out, '0);
      $display("[TB] msg %s len=%0d blocks=%0d done", tag, msg.size(), exp_loads.size());
   endtask

   initial begin
      int cnt;
      n_tests   = 0;
      n_fail    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      in_bytes  = 4'd0;
      out_ready = 1'b0;

      repeat (3) @(negedge clock);
      chk("reset in_ready", 64'(in_ready), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("reset idle in_ready", 64'(in_ready), 64'd1);
      chk("reset perm_run", 64'(perm_run), 64'd0);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk_state("reset perm_state_out", perm_state_out, '0);
      chk_state("reset out_state", out_state, '0);

      // Empty message.
      msg.delete();
      build_expect();
      empty_ref = exp_out;
      run_msg("empty", 0);

      // "abc" with output backpressure.
      msg.delete();
      msg.push_back(8'h61);
      msg.push_back(8'h62);
      msg.push_back(8'h63);
      run_msg("abc_bp", 5);

      fill_msg(135);
      run_msg("len135", 0);
      fill_msg(136);
      run_msg("len136", 2);
      fill_msg(16);
      run_msg("len16", 1);
      fill_msg(272);
      run_msg("len272", 0);

      for (int r = 0; r < 8; r++) begin
         fill_msg((r % 2 == 0) ? 8 * $urandom_range(0, 40) : $urandom_range(0, 300));
         run_msg($sformatf("rand%0d", r), $urandom_range(0, 3));
      end

      // Reset while the permutation is running.
      msg.delete();
      fork
         stream_msg();
      join_none
      cnt = 0;
      while (perm_run !== 1'b1 && cnt < 3000) begin
         @(negedge clock);
         cnt++;
      end
      chk("midrun perm_run seen", 64'(perm_run), 64'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrun in_ready during reset", 64'(in_ready), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("midrun perm_run", 64'(perm_run), 64'd0);
      chk("midrun in_ready", 64'(in_ready), 64'd1);
      chk("midrun out_valid", 64'(out_valid), 64'd0);
      chk_state("midrun S", perm_state_out, '0);
      chk_state("midrun out_state", out_state, '0);
      @(negedge clock);

      msg.delete();
      run_msg("empty_after_reset", 0);
      chk_state("empty repeat", exp_out, empty_ref);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/shake256_absorb.md
# shake256_absorb

Sponge absorb/pad front end for the SHAKE256 datapath, sitting directly upstream of the KECCAK_f permutation core. It accepts a message as a stream of 64-bit words and XORs each word into the 1600-bit state at rate 136 bytes. It applies SHAKE padding (0x1F … 0x80) and drives KECCAK_f once per full or final block. After the final permutation it hands the absorbed state to the downstream squeeze stage.

## Interface
- RATE_LANES, 17, 64-bit lanes per rate block (136 bytes)
- DSBYTE, 8'h1F, domain-separation/pad-start byte
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  input word valid
- in_ready  out  1  block accepts a word this cycle
- in_data  in  64  message word; message byte 0 of the word at [63:56]
- in_last  in  1  final word of message
- in_bytes  in  4  valid bytes in the last word, 0..8; ignored unless in_last
- perm_state_out  out  1600  state to KECCAK_f S_in; state byte i at [1599-8i -: 8]
- perm_run  out  1  drives KECCAK_f reset: low loads S_in, high runs rounds
- perm_done  in  1  KECCAK_f done
- perm_state_in  in  1600  KECCAK_f S_out
- out_valid  out  1  absorbed state valid
- out_ready  in  1  squeeze stage accepts state
- out_state  out  1600  absorbed state, same byte order

## Operation
- State register S (1600 b), lane counter lane (0..16), flag fin. perm_state_out = S always.
- FSM: ABSORB, LOAD, RUN, PADBLK, OUTPUT.
- ABSORB: in_ready=1. Accept on in_valid & in_ready.
  - Non-last word: S lane[lane] ^= in_data. If lane==16, go LOAD with fin=0; otherwise lane++.
  - Last word, p = 8*lane + in_bytes:
    - Bytes at or beyond in_bytes are masked to zero before the XOR.
    - If p<136: XOR DSBYTE into byte p and 0x80 into byte 135. If p==135, the combined value is 0x9F. Go LOAD with fin=1.
    - If p==136 (lane 16, in_bytes=8): XOR the data only, go LOAD with fin=0 and set the pending pad flag.
- LOAD: perm_run=0 for exactly one cycle, then RUN.
- RUN: perm_run=1. On the first cycle perm_done=1: S <= perm_state_in, lane <= 0, perm_run drops next cycle. Next state:
  - pad pending → PADBLK
  - fin → OUTPUT
  - otherwise → ABSORB
- PADBLK: one cycle. S byte 0 ^= DSBYTE, byte 135 ^= 0x80, clear the pad flag, fin=1, go LOAD.
- OUTPUT: out_valid=1, out_state=S, in_ready=0. On out_ready: S <= 0, lane <= 0, fin <= 0, go ABSORB.
- in_bytes > 8 with in_last is illegal; behaviour is undefined, and an assertion flags it.

## Timing
- Reset (any state, including mid-RUN or OUTPUT) → next cycle: S=0, lane=0, fin=0, pad flag=0, state ABSORB. Outputs: in_ready=1, perm_run=0, out_valid=0, perm_state_out=0, out_state=0. While reset is high, in_ready=0.
- Throughput: one word per cycle in ABSORB. A full block takes 17 accept cycles, then 1 LOAD cycle, then the KECCAK_f latency, then 1 capture cycle.
- Handshakes follow valid/ready rules: in_data, in_last and in_bytes are sampled only on accept. out_state is stable while out_valid=1 and out_ready=0.
- in_ready=0 in LOAD, RUN, PADBLK and OUTPUT. A new message can start the cycle after the OUTPUT handshake.
- perm_done seen outside RUN is ignored.

## Structure
- Package shake_pkg holds:
  - constants RATE_LANES=17, RATE_BYTES=136, DSBYTE_SHAKE256=8'h1F
  - typedefs state_t (logic [1599:0]) and lane_t (logic [63:0])
  - the FSM enum
- One sub-module, shake_pad_lane: combinational. Takes a lane word, the byte count and the lane index; returns the masked and padded 64-bit XOR value. Reused for the last-word and PADBLK paths.

## Test plan
- Empty message: one word, in_last=1, in_bytes=0.
  - Required: LOAD presents S with byte0=0x1F, byte135=0x80, all else 0; one permutation.
  - With a real KECCAK_f: out_state[1599:1536]=64'h46b9dd2b0ba88d13.
- "abc": in_data=64'h616263FFFFFFFFFF, in_bytes=3.
  - Required: block bytes 61 62 63 1F, byte135=0x80; the FF bytes are ignored.
  - out_state[1599:1536]=64'h483366601360a877.
- 135-byte message: 17 words, last with in_bytes=7.
  - Required: byte135=0x9F, exactly one LOAD/RUN, then OUTPUT.
- 136-byte message: 17 words, last with in_bytes=8.
  - Required: two permutations. The second is preceded by PADBLK, applying 0x1F at byte0 and 0x80 at byte135 on the permuted state.
- Output backpressure: out_ready low for 5 cycles.
  - Required: out_valid=1, out_state stable, in_ready=0 throughout. After the handshake, in_ready=1 and S=0.
- Reset asserted mid-RUN.
  - Required: next cycle perm_run=0, S=0, lane=0, in_ready=1, out_valid=0. A following empty message reproduces scenario 1.
